// File: rtl/parse_field_pkg.sv
// parse_field_pkg: shared types and helpers for the parse_field_window block.
//   win_state_e : window tracking state (SKIP before the window, CAPT inside it,
//                 DONE once the window has been fully captured).
//   cnt_width() : width of the per-frame beat counter. It must hold 0..OFFSET+FIELD_LEN.
package parse_field_pkg;

  typedef enum logic [1:0] {
    SKIP = 2'd0,
    CAPT = 2'd1,
    DONE = 2'd2
  } win_state_e;

  function automatic int unsigned cnt_width(input int unsigned offset,
                                            input int unsigned field_len);
    return $clog2(offset + field_len + 1);
  endfunction

endpackage

// File: rtl/axi_stream_inf.sv
// axi_stream_inf: minimal AXI4-Stream bundle with its own clock and reset.
//   aclk, aresetn : clock and active-low reset shared by both ends
//   tvalid/tready : handshake
//   tdata         : DSIZE-bit beat
//   tkeep         : byte enables, one per 8 bits of tdata
//   tuser, tlast  : sideband and end-of-frame marker
// Modports: slaver (sink side) and master (source side).
interface axi_stream_inf #(
  parameter int unsigned DSIZE = 8
) (
  input logic aclk,
  input logic aresetn
);
  localparam int unsigned KSIZE = (DSIZE + 7) / 8;

  logic             tvalid;
  logic             tready;
  logic [DSIZE-1:0] tdata;
  logic [KSIZE-1:0] tkeep;
  logic             tuser;
  logic             tlast;

  modport slaver (
    input  aclk, aresetn, tvalid, tdata, tkeep, tuser, tlast,
    output tready
  );

  modport master (
    input  aclk, aresetn, tready,
    output tvalid, tdata, tkeep, tuser, tlast
  );

endinterface

// File: rtl/parse_field_window_cnt.sv
// parse_field_window_cnt: per-frame beat counter, window state and drop decode.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   hs_i          : input handshake (tvalid & tready) this cycle
//   last_i        : tlast of the current input beat
//   bcnt_o        : beats accepted so far in the frame (saturates at OFFSET+FIELD_LEN)
//   win_o         : the current beat lies inside the capture window
//   win_end_o     : the current beat is the final window beat
//   drop_o        : the current beat is consumed locally instead of forwarded
module parse_field_window_cnt
  import parse_field_pkg::*;
#(
  parameter int unsigned OFFSET    = 0,
  parameter int unsigned FIELD_LEN = 16,
  parameter bit          STRIP     = 1'b0,
  parameter int unsigned CW        = cnt_width(OFFSET, FIELD_LEN)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          hs_i,
  input  logic          last_i,
  output logic [CW-1:0] bcnt_o,
  output logic          win_o,
  output logic          win_end_o,
  output logic          drop_o
);

  localparam logic [CW-1:0] Off     = CW'(OFFSET);
  localparam logic [CW-1:0] Total   = CW'(OFFSET + FIELD_LEN);
  localparam logic [CW-1:0] WinEnd  = CW'(OFFSET + FIELD_LEN - 1);
  // With no leading skip the very first beat of a frame is already a window beat.
  localparam win_state_e    StFirst = (OFFSET == 0) ? CAPT : SKIP;

  logic [CW-1:0] bcnt_q, bcnt_d, bcnt_eff;
  win_state_e    state_q, state_d, state_eff;

  // The pass-through path stays live during reset, so decode from the reset
  // values rather than whatever the flops still hold.
  assign bcnt_eff  = rst_ni ? bcnt_q  : '0;
  assign state_eff = rst_ni ? state_q : StFirst;

  always_comb begin
    bcnt_d  = bcnt_q;
    state_d = state_q;
    if (hs_i) begin
      if (last_i) begin
        bcnt_d  = '0;
        state_d = StFirst;
      end else begin
        if (bcnt_q != Total) bcnt_d = bcnt_q + 1'b1;
        case (state_q)
          SKIP:    if (bcnt_q + 1'b1 == Off) state_d = CAPT;
          CAPT:    if (bcnt_q == WinEnd) state_d = DONE;
          default: state_d = state_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      bcnt_q  <= '0;
      state_q <= StFirst;
    end else begin
      bcnt_q  <= bcnt_d;
      state_q <= state_d;
    end
  end

  assign bcnt_o    = bcnt_eff;
  assign win_o     = (state_eff == CAPT);
  assign win_end_o = win_o && (bcnt_eff == WinEnd);
  // A window beat carrying tlast is always forwarded so the frame boundary survives.
  assign drop_o    = STRIP && win_o && !last_i;

endmodule

// File: rtl/parse_field_window.sv
// parse_field_window: captures a FIELD_LEN-beat window starting OFFSET beats into
// each frame of an AXI-Stream, while passing the stream through with zero latency.
//   cm_tb_s   : input stream (slaver); its aclk/aresetn clock and reset the block
//   cm_tb_m   : output stream (master); window beats are removed when STRIP=1
//   value     : captured window, window beat 0 in the MSBs
//   out_valid : value complete and stable; held until the next frame's first beat
//   short_err : one-cycle pulse when a frame ends before its window completes
// Optional feature: define PARSE_FIELD_WINDOW_SHORT_ERR_EN to build the short-frame
// detector; otherwise short_err is tied low.
module parse_field_window
  import parse_field_pkg::*;
#(
  parameter int unsigned DSIZE     = 8,
  parameter int unsigned FIELD_LEN = 16,
  parameter int unsigned OFFSET    = 0,
  parameter bit          STRIP     = 1'b0
) (
  axi_stream_inf.slaver              cm_tb_s,
  axi_stream_inf.master              cm_tb_m,
  output logic [DSIZE*FIELD_LEN-1:0] value,
  output logic                       out_valid,
  output logic                       short_err
);

  localparam int unsigned   CW  = cnt_width(OFFSET, FIELD_LEN);
  localparam logic [CW-1:0] Off = CW'(OFFSET);

  if (cm_tb_s.DSIZE != DSIZE) begin : g_bad_dsize
    $error("parse_field_window: DSIZE %0d differs from cm_tb_s.DSIZE", DSIZE);
  end
  if (FIELD_LEN < 1 || FIELD_LEN > 256) begin : g_bad_len
    $error("parse_field_window: FIELD_LEN %0d outside 1..256", FIELD_LEN);
  end
  if (OFFSET > 255) begin : g_bad_off
    $error("parse_field_window: OFFSET %0d outside 0..255", OFFSET);
  end

  logic          hs;
  logic          win;
  logic          win_end;
  logic          drop;
  logic [CW-1:0] bcnt;

  parse_field_window_cnt #(
    .OFFSET    (OFFSET),
    .FIELD_LEN (FIELD_LEN),
    .STRIP     (STRIP),
    .CW        (CW)
  ) u_cnt (
    .clk_i     (cm_tb_s.aclk),
    .rst_ni    (cm_tb_s.aresetn),
    .hs_i      (hs),
    .last_i    (cm_tb_s.tlast),
    .bcnt_o    (bcnt),
    .win_o     (win),
    .win_end_o (win_end),
    .drop_o    (drop)
  );

  // Combinational pass-through; a dropped beat is accepted here and never shown
  // downstream.
  assign cm_tb_m.tdata  = cm_tb_s.tdata;
  assign cm_tb_m.tkeep  = cm_tb_s.tkeep;
  assign cm_tb_m.tuser  = cm_tb_s.tuser;
  assign cm_tb_m.tlast  = cm_tb_s.tlast;
  assign cm_tb_m.tvalid = cm_tb_s.tvalid & ~drop;
  assign cm_tb_s.tready = drop | cm_tb_m.tready;

  assign hs = cm_tb_s.tvalid & cm_tb_s.tready;

  logic [FIELD_LEN-1:0][DSIZE-1:0] value_q, value_d;
  logic                            out_valid_q, out_valid_d;
  logic [CW-1:0]                   slot;

  assign slot = bcnt - Off;

  // Slot 0 of the window sits in the top element so it lands in the MSBs.
  always_comb begin
    value_d = value_q;
    if (hs && win) begin
      for (int unsigned i = 0; i < FIELD_LEN; i++) begin
        if (slot == CW'(i)) value_d[FIELD_LEN-1-i] = cm_tb_s.tdata;
      end
    end
  end

  // Completion wins over the clear so a one-beat window at the frame start still
  // reports valid.
  always_comb begin
    out_valid_d = out_valid_q;
    if (hs && win_end) begin
      out_valid_d = 1'b1;
    end else if (hs && (bcnt == '0)) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge cm_tb_s.aclk) begin
    if (!cm_tb_s.aresetn) begin
      value_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      value_q     <= value_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign value     = value_q;
  assign out_valid = out_valid_q;

`ifdef PARSE_FIELD_WINDOW_SHORT_ERR_EN
  localparam logic [CW-1:0] WinEnd = CW'(OFFSET + FIELD_LEN - 1);

  logic short_err_q, short_err_d;

  // A tlast below the final window index means the window can no longer complete.
  assign short_err_d = hs && cm_tb_s.tlast && (bcnt < WinEnd);

  always_ff @(posedge cm_tb_s.aclk) begin
    if (!cm_tb_s.aresetn) begin
      short_err_q <= 1'b0;
    end else begin
      short_err_q <= short_err_d;
    end
  end

  assign short_err = short_err_q;
`else
  assign short_err = 1'b0;
`endif

endmodule

// File: tb/tb_parse_field_window.sv
// Scoreboard bench for parse_field_window. Three instances share one driver:
//   A: OFFSET=2 STRIP=0, B: OFFSET=2 STRIP=1, C: OFFSET=0 STRIP=1 (FIELD_LEN=4, DSIZE=8).
// Only the selected instance sees tvalid. Expected beats and windows are queued when
// stimulus is issued; a negedge monitor pops and compares whenever an output appears.
module tb_parse_field_window;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic       drv_valid = 1'b0;
  logic [7:0] drv_data  = 8'h00;
  logic       drv_last  = 1'b0;
  int         sel       = 0;
  logic       rdy       = 1'b1;
  bit         rand_mode = 1'b0;
  int         cyc       = 0;
  int         win_cyc   = 0;
  int         rise_cyc  [3];
  int         n_chk     = 0;
  int         n_fail    = 0;

  logic [8:0]  exp_beat_q [3][$];
  logic [31:0] exp_val_q  [3][$];
  int          exp_short  [3];
  int          got_short  [3];
  logic        ov_prev    [3];

  logic [31:0] val0, val1, val2;
  logic        ov0, ov1, ov2;
  logic        se0, se1, se2;
  logic        hs0, hs1, hs2, hs_sel;

  axi_stream_inf #(.DSIZE(8)) s0 (.aclk(clk), .aresetn(rstn));
  axi_stream_inf #(.DSIZE(8)) m0 (.aclk(clk), .aresetn(rstn));
  axi_stream_inf #(.DSIZE(8)) s1 (.aclk(clk), .aresetn(rstn));
  axi_stream_inf #(.DSIZE(8)) m1 (.aclk(clk), .aresetn(rstn));
  axi_stream_inf #(.DSIZE(8)) s2 (.aclk(clk), .aresetn(rstn));
  axi_stream_inf #(.DSIZE(8)) m2 (.aclk(clk), .aresetn(rstn));

  assign s0.tvalid = drv_valid && (sel == 0);
  assign s0.tdata  = drv_data;
  assign s0.tlast  = drv_last;
  assign s0.tkeep  = 1'b1;
  assign s0.tuser  = 1'b0;
  assign m0.tready = rdy;

  assign s1.tvalid = drv_valid && (sel == 1);
  assign s1.tdata  = drv_data;
  assign s1.tlast  = drv_last;
  assign s1.tkeep  = 1'b1;
  assign s1.tuser  = 1'b0;
  assign m1.tready = rdy;

  assign s2.tvalid = drv_valid && (sel == 2);
  assign s2.tdata  = drv_data;
  assign s2.tlast  = drv_last;
  assign s2.tkeep  = 1'b1;
  assign s2.tuser  = 1'b0;
  assign m2.tready = rdy;

  assign hs0    = s0.tvalid & s0.tready;
  assign hs1    = s1.tvalid & s1.tready;
  assign hs2    = s2.tvalid & s2.tready;
  assign hs_sel = (sel == 0) ? hs0 : (sel == 1) ? hs1 : hs2;

  parse_field_window #(.DSIZE(8), .FIELD_LEN(4), .OFFSET(2), .STRIP(1'b0)) u_dut_a (
    .cm_tb_s(s0), .cm_tb_m(m0), .value(val0), .out_valid(ov0), .short_err(se0)
  );
  parse_field_window #(.DSIZE(8), .FIELD_LEN(4), .OFFSET(2), .STRIP(1'b1)) u_dut_b (
    .cm_tb_s(s1), .cm_tb_m(m1), .value(val1), .out_valid(ov1), .short_err(se1)
  );
  parse_field_window #(.DSIZE(8), .FIELD_LEN(4), .OFFSET(0), .STRIP(1'b1)) u_dut_c (
    .cm_tb_s(s2), .cm_tb_m(m2), .value(val2), .out_valid(ov2), .short_err(se2)
  );

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      rdy = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_beat(input int k, input logic [7:0] d, input logic l);
    exp_beat_q[k].push_back({l, d});
  endtask

  // Reference for the random phase: FIELD_LEN=4, data = base+i.
  task automatic expect_frame(input int k, input logic [7:0] base, input int n);
    int         off;
    bit         strip;
    bit         last;
    bit         inwin;
    logic [7:0] d;
    off   = (k == 2) ? 0 : 2;
    strip = (k != 0);
    for (int i = 0; i < n; i++) begin
      d     = base + 8'(i);
      last  = (i == n - 1);
      inwin = (i >= off) && (i < off + 4);
      if (!(strip && inwin && !last)) exp_beat_q[k].push_back({last, d});
    end
    if (n >= off + 4) begin
      exp_val_q[k].push_back({base + 8'(off), base + 8'(off + 1),
                              base + 8'(off + 2), base + 8'(off + 3)});
    end
`ifdef PARSE_FIELD_WINDOW_SHORT_ERR_EN
    if (n < off + 4) exp_short[k]++;
`endif
  endtask

  task automatic send_beat(input int k, input logic [7:0] d, input logic l, input bit mark);
    bit got;
    got       = 1'b0;
    sel       = k;
    drv_data  = d;
    drv_last  = l;
    drv_valid = 1'b1;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      if (hs_sel) begin
        got = 1'b1;
        if (mark) win_cyc = cyc;
      end
      @(posedge clk);
      #1;
    end
    drv_valid = 1'b0;
    drv_last  = 1'b0;
    chk("input_handshake", {31'd0, got}, 32'd1);
  endtask

  task automatic send_frame(input int k, input logic [7:0] base, input int n,
                            input bit with_last, input int win_idx);
    for (int i = 0; i < n; i++) begin
      if (rand_mode) tick($urandom_range(0, 2));
      send_beat(k, base + 8'(i), with_last && (i == n - 1), i == win_idx);
    end
  endtask

  task automatic mon(input int k, input logic mv, input logic mr, input logic [7:0] md,
                     input logic ml, input logic ov, input logic [31:0] val, input logic se);
    logic [8:0]  eb;
    logic [31:0] ev;
    if (mv && mr) begin
      if (exp_beat_q[k].size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL out_beat[%0d]: got data %h last %b, expected no beat", k, md, ml);
      end else begin
        eb = exp_beat_q[k].pop_front();
        chk($sformatf("out_beat[%0d] {last,data}", k), {23'd0, ml, md}, {23'd0, eb});
      end
    end
    if (ov && !ov_prev[k]) begin
      rise_cyc[k] = cyc;
      if (exp_val_q[k].size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL value[%0d]: got %h with out_valid, expected no window", k, val);
      end else begin
        ev = exp_val_q[k].pop_front();
        chk($sformatf("value[%0d]", k), val, ev);
      end
    end
    ov_prev[k] = ov;
    if (se) got_short[k]++;
  endtask

  always @(negedge clk) begin
    mon(0, m0.tvalid, m0.tready, m0.tdata, m0.tlast, ov0, val0, se0);
    mon(1, m1.tvalid, m1.tready, m1.tdata, m1.tlast, ov1, val1, se1);
    mon(2, m2.tvalid, m2.tready, m2.tdata, m2.tlast, ov2, val2, se2);
  end

  initial begin
    int         k;
    int         n;
    logic [7:0] b;
    for (int i = 0; i < 3; i++) begin
      exp_short[i] = 0;
      got_short[i] = 0;
      ov_prev[i]   = 1'b0;
      rise_cyc[i]  = 0;
    end

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_value_a", val0, 32'h0);
    chk("rst_value_b", val1, 32'h0);
    chk("rst_value_c", val2, 32'h0);
    chk("rst_out_valid_a", {31'd0, ov0}, 32'd0);
    chk("rst_out_valid_b", {31'd0, ov1}, 32'd0);
    chk("rst_out_valid_c", {31'd0, ov2}, 32'd0);
    chk("rst_short_err_a", {31'd0, se0}, 32'd0);
    chk("rst_short_err_b", {31'd0, se1}, 32'd0);
    chk("rst_short_err_c", {31'd0, se2}, 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    tick(1);

    // A: frame 00..07, all eight beats forwarded, window 02 03 04 05.
    for (int i = 0; i < 8; i++) expect_beat(0, 8'(i), i == 7);
    exp_val_q[0].push_back(32'h02030405);
    send_frame(0, 8'h00, 8, 1'b1, 5);
    tick(2);
    chk("out_valid_rise_after_beat5", rise_cyc[0], win_cyc + 1);
    chk("out_valid_held_a", {31'd0, ov0}, 32'd1);

    // B: same frame with strip, window beats 02..05 removed.
    expect_beat(1, 8'h00, 1'b0);
    expect_beat(1, 8'h01, 1'b0);
    expect_beat(1, 8'h06, 1'b0);
    expect_beat(1, 8'h07, 1'b1);
    exp_val_q[1].push_back(32'h02030405);
    send_frame(1, 8'h00, 8, 1'b1, -1);
    tick(2);

    // Short frame 00..03: no window; on B the tlast window beat is still forwarded.
    for (int i = 0; i < 4; i++) expect_beat(0, 8'(i), i == 3);
    expect_beat(1, 8'h00, 1'b0);
    expect_beat(1, 8'h01, 1'b0);
    expect_beat(1, 8'h03, 1'b1);
`ifdef PARSE_FIELD_WINDOW_SHORT_ERR_EN
    exp_short[0]++;
    exp_short[1]++;
`endif
    send_frame(0, 8'h00, 4, 1'b1, -1);
    tick(2);
    chk("short_out_valid_a", {31'd0, ov0}, 32'd0);
    send_frame(1, 8'h00, 4, 1'b1, -1);
    tick(2);
    chk("short_out_valid_b", {31'd0, ov1}, 32'd0);

    // C: OFFSET=0, AA BB CC dropped, DD forwarded with tlast and captured.
    expect_beat(2, 8'hDD, 1'b1);
    exp_val_q[2].push_back(32'hAABBCCDD);
    send_beat(2, 8'hAA, 1'b0, 1'b0);
    send_beat(2, 8'hBB, 1'b0, 1'b0);
    send_beat(2, 8'hCC, 1'b0, 1'b0);
    send_beat(2, 8'hDD, 1'b1, 1'b0);
    tick(2);
    chk("exact_frame_out_valid_c", {31'd0, ov2}, 32'd1);

    // Random gaps and backpressure, 100 frames of 1..12 beats.
    rand_mode = 1'b1;
    for (int f = 0; f < 100; f++) begin
      k = $urandom_range(0, 2);
      n = $urandom_range(1, 12);
      b = 8'($urandom_range(0, 255));
      expect_frame(k, b, n);
      send_frame(k, b, n, 1'b1, -1);
    end
    rand_mode = 1'b0;
    tick(3);

    // A: reset in the middle of the window, then frame 10..17.
    for (int i = 0; i < 4; i++) expect_beat(0, 8'(i), 1'b0);
    send_frame(0, 8'h00, 4, 1'b0, -1);
    rstn = 1'b0;
    tick(2);
    chk("midreset_value_a", val0, 32'h0);
    chk("midreset_out_valid_a", {31'd0, ov0}, 32'd0);
    rstn = 1'b1;
    tick(1);
    for (int i = 0; i < 8; i++) expect_beat(0, 8'h10 + 8'(i), i == 7);
    exp_val_q[0].push_back(32'h12131415);
    send_frame(0, 8'h10, 8, 1'b1, -1);
    tick(4);

    for (int i = 0; i < 3; i++) begin
      chk($sformatf("beats_outstanding[%0d]", i), exp_beat_q[i].size(), 32'd0);
      chk($sformatf("windows_outstanding[%0d]", i), exp_val_q[i].size(), 32'd0);
      chk($sformatf("short_err_pulses[%0d]", i), got_short[i], exp_short[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/parse_field_window.md
PARSE_FIELD_WINDOW -- requirements
Module: parse_field_window

Interface
REQ-001 SHALL have parameter DSIZE, default 8: beat width in bits; must equal cm_tb_s.DSIZE, with an elaboration-time $error on mismatch.
REQ-002 SHALL have parameter FIELD_LEN, default 16: number of beats captured per frame, legal range 1..256.
REQ-003 SHALL have parameter OFFSET, default 0: number of leading beats per frame skipped before capture starts, legal range 0..255.
REQ-004 SHALL have parameter STRIP, default 0: 1 removes the captured beats from the output stream; 0 passes every beat through.
REQ-005 SHALL have port cm_tb_s.aclk, input, 1 bit: the single clock; every register samples on its rising edge.
REQ-006 SHALL have port cm_tb_s.aresetn, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port cm_tb_s, axi_stream_inf.slaver: the input frame stream.
REQ-008 SHALL have port cm_tb_m, axi_stream_inf.master: the output frame stream, same DSIZE, clocked by cm_tb_s.aclk.
REQ-009 SHALL have port value, output, DSIZE*FIELD_LEN bits: the captured window; window beat 0 occupies the MSBs.
REQ-010 SHALL have port out_valid, output, 1 bit: value is complete and stable.
REQ-011 SHALL have port short_err, output, 1 bit: one-cycle pulse when a frame ends before the window is complete.

Function
REQ-012 SHALL keep a beat counter bcnt, counting handshakes (tvalid & tready on cm_tb_s) within the current frame, saturating at OFFSET+FIELD_LEN, and returning to 0 after a tlast handshake.
REQ-013 SHALL treat a beat as a window beat when OFFSET <= bcnt < OFFSET+FIELD_LEN; on its handshake it SHALL write tdata into slot bcnt-OFFSET of value.
REQ-014 SHALL assert out_valid the cycle after the handshake of window beat FIELD_LEN-1.
REQ-015 SHALL hold out_valid high, with value frozen, until the first handshake of the next frame; out_valid SHALL drop the cycle after that handshake.
REQ-016 SHALL leave value slots unwritten by a short frame holding their previous contents; out_valid SHALL NOT assert for a short frame.
REQ-017 SHALL pass the stream with zero latency and purely combinationally: tdata, tkeep, tuser and tlast copied unchanged.
REQ-018 With STRIP=0: cm_tb_m.tvalid = cm_tb_s.tvalid and cm_tb_s.tready = cm_tb_m.tready.
REQ-019 With STRIP=1, for a window beat (drop=1): cm_tb_m.tvalid = 0 and cm_tb_s.tready = 1, so the beat is consumed locally.
REQ-020 SHALL never drop a window beat that carries tlast, even with STRIP=1; it is forwarded (and still captured) to preserve framing.
REQ-021 SHALL never create, reorder or duplicate beats; output beat count = input beat count minus the dropped beats.
REQ-022 SHALL treat a frame of length OFFSET+FIELD_LEN exactly as complete: out_valid asserts and short_err stays 0.
REQ-023 SHALL let a tlast handshake and the final window beat in the same cycle produce a complete window; bcnt then resets to 0.

Reset
REQ-024 While aresetn=0 at a clock edge: bcnt=0, value=0, out_valid=0, short_err=0.
REQ-025 A mid-frame reset SHALL discard the partial frame; the first handshake after reset is beat 0 of a new frame.
REQ-026 During reset the pass-through SHALL remain combinational; with STRIP=1, drop evaluates with bcnt=0.

Configuration
REQ-027 With macro PARSE_FIELD_WINDOW_SHORT_ERR_EN defined: short_err pulses for one cycle after a tlast handshake that occurs while bcnt < OFFSET+FIELD_LEN-1 and the last beat does not complete the window.
REQ-028 Without PARSE_FIELD_WINDOW_SHORT_ERR_EN: short_err is tied to 0 and no detection logic is synthesised.

Structure
REQ-029 Shared package parse_field_pkg SHALL hold the counter-width function (clog2 of OFFSET+FIELD_LEN+1) and the typedef for the window-state enum {SKIP, CAPT, DONE}.
REQ-030 Sub-module parse_field_window_cnt SHALL hold bcnt, the SKIP/CAPT/DONE state and the drop decode; capture and the output mux stay in the top module.
REQ-031 State transitions SHALL be:
- SKIP to CAPT when bcnt reaches OFFSET (a module starting with OFFSET=0 enters CAPT directly);
- CAPT to DONE after window beat FIELD_LEN-1;
- any state to SKIP (or CAPT when OFFSET=0) on a tlast handshake.

Verification
REQ-032 DSIZE=8, FIELD_LEN=4, OFFSET=2, STRIP=0; frame 00..07 -> value=0x02030405, out_valid rises the cycle after beat 05, and 8 beats appear on the output.
REQ-033 Same config with STRIP=1 -> output frame 00 01 06 07 with tlast on 07; value=0x02030405.
REQ-034 Same config; frame 00..03 with tlast on 03 -> out_valid stays 0, short_err pulses once (macro on) or stays 0 (macro off), and the forwarded tlast beat is preserved.
REQ-035 STRIP=1, FIELD_LEN=4, OFFSET=0; frame AA BB CC DD with tlast on DD -> AA, BB, CC dropped, DD forwarded with tlast, value=0xAABBCCDD, out_valid=1.
REQ-036 Random tvalid/tready backpressure over 100 frames of 1..12 beats -> scoreboard matches every value and output stream.
REQ-037 Reset asserted mid-window, then a new frame 10..17 -> value=0x12131415 with no residue from the interrupted frame.
